// File: rtl/nf_seven_seg_dyn_pkg.sv
// Shared constants for the scanning seven-segment controller: segment bit
// positions, the hex font and the all-off pattern.
package nf_seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Element 0 is the glyph for nibble 0; bits are {g,f,e,d,c,b,a}.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/nf_seven_seg_dyn_hex2seg.sv
// Combinational nibble to seven-segment glyph decode ({g,f,e,d,c,b,a}).
module nf_hex2seg
  import nf_seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  assign seg7 = HEX_FONT[nib];

endmodule

// File: rtl/nf_seven_seg_dyn.sv
// Time-multiplexed seven-segment controller with frame-synchronous updates.
// Define NF_SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module nf_seven_seg_dyn
  import nf_seven_seg_pkg::*;
#(
  parameter int hn       = 8,
  parameter int scan_div = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [hn*4-1:0]   hex,
  input  logic [hn-1:0]     dp,
  input  logic [hn-1:0]     den,
  input  logic              upd,
  input  logic              cc_ca,
  output logic [7:0]        seg,
  output logic [hn-1:0]     dig,
  output logic              frame
);

  localparam int IW = $clog2(hn);
  localparam int PW = $clog2(scan_div);

  logic [PW-1:0]   pc_q, pc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [hn*4-1:0] hex_p_q, hex_p_d, hex_a_q, hex_a_d;
  logic [hn-1:0]   dp_p_q, dp_p_d, dp_a_q, dp_a_d;
  logic [hn-1:0]   den_p_q, den_p_d, den_a_q, den_a_d;
  logic            pend_q, pend_d;
  logic            bnd_q, bnd_d;
  logic            frame_q, frame_d;
  logic [7:0]      seg_q, seg_d;
  logic [hn-1:0]   dig_q, dig_d;

  logic            pc_last, boundary;
  logic [3:0]      a_nib [hn];
  logic [3:0]      nib;
  logic [6:0]      glyph;
  logic            lz_blank;
  logic [7:0]      raw;
  logic [hn-1:0]   one_hot;

  for (genvar g = 0; g < hn; g++) begin : g_nib
    assign a_nib[g] = hex_a_q[g*4 +: 4];
  end

  assign nib = a_nib[idx_q];

  nf_hex2seg u_hex2seg (
    .nib  (nib),
    .seg7 (glyph)
  );

`ifdef NF_SEVEN_SEG_LZB_EN
  logic upper_nz;
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < hn; i++) begin
      if (IW'(i) >= idx_q && a_nib[i] != 4'h0) upper_nz = 1'b1;
    end
    lz_blank = (idx_q != '0) && !upper_nz;
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    pc_last  = (pc_q == PW'(scan_div - 1));
    boundary = pc_last && (idx_q == IW'(hn - 1));

    pc_d  = pc_last ? '0 : pc_q + PW'(1);
    idx_d = idx_q;
    if (pc_last) idx_d = (idx_q == IW'(hn - 1)) ? '0 : idx_q + IW'(1);

    hex_p_d = hex_p_q;
    dp_p_d  = dp_p_q;
    den_p_d = den_p_q;
    hex_a_d = hex_a_q;
    dp_a_d  = dp_a_q;
    den_a_d = den_a_q;
    pend_d  = pend_q;

    // An update landing on the boundary goes straight to the active set.
    if (upd) begin
      hex_p_d = hex;
      dp_p_d  = dp;
      den_p_d = den;
      if (boundary) begin
        hex_a_d = hex;
        dp_a_d  = dp;
        den_a_d = den;
        pend_d  = 1'b0;
      end else begin
        pend_d  = 1'b1;
      end
    end else if (boundary && pend_q) begin
      hex_a_d = hex_p_q;
      dp_a_d  = dp_p_q;
      den_a_d = den_p_q;
      pend_d  = 1'b0;
    end

    // Frame follows the boundary by one cycle to line up with digit 0 on dig.
    bnd_d   = boundary;
    frame_d = bnd_q;

    raw = SEG_OFF;
    if (den_a_q[idx_q] && !lz_blank) begin
      raw[SEG_G:SEG_A] = glyph;
      raw[SEG_DP]      = dp_a_q[idx_q];
    end
    one_hot = {{(hn-1){1'b0}}, 1'b1} << idx_q;
    seg_d   = raw ^ {8{cc_ca}};
    dig_d   = one_hot ^ {hn{cc_ca}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      idx_q   <= '0;
      hex_p_q <= '0;
      dp_p_q  <= '0;
      den_p_q <= '0;
      hex_a_q <= '0;
      dp_a_q  <= '0;
      den_a_q <= '0;
      pend_q  <= 1'b0;
      bnd_q   <= 1'b0;
      frame_q <= 1'b0;
      seg_q   <= {8{cc_ca}};
      dig_q   <= {hn{cc_ca}};
    end else begin
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      hex_p_q <= hex_p_d;
      dp_p_q  <= dp_p_d;
      den_p_q <= den_p_d;
      hex_a_q <= hex_a_d;
      dp_a_q  <= dp_a_d;
      den_a_q <= den_a_d;
      pend_q  <= pend_d;
      bnd_q   <= bnd_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg   = seg_q;
  assign dig   = dig_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_nf_seven_seg_dyn.sv
// Self-checking bench for nf_seven_seg_dyn (hn=4, scan_div=4): cycle model
// plus directed literal checks; LZB expectations follow NF_SEVEN_SEG_LZB_EN.
module tb_nf_seven_seg_dyn;

  localparam int HN = 4;
  localparam int SD = 4;
  localparam int FR = HN * SD;
`ifdef NF_SEVEN_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex;
  logic [3:0]  dp, den;
  logic        upd, cc_ca;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  nf_seven_seg_dyn #(.hn(HN), .scan_div(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .hex   (hex),
    .dp    (dp),
    .den   (den),
    .upd   (upd),
    .cc_ca (cc_ca),
    .seg   (seg),
    .dig   (dig),
    .frame (frame)
  );

  always #5 clk = ~clk;

  // Behavioural model: time since reset release decides which digit is shown
  // and where frame boundaries fall.
  int          m_k = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_a_hex, m_p_hex;
  logic [3:0]  m_a_dp, m_p_dp, m_a_den, m_p_den;
  bit          m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_frame;

  always @(posedge clk) begin : model
    int d;
    logic [3:0] n;
    logic [7:0] r;
    bit bnd;
    if (reset) begin
      m_k = 0; m_pend = 1'b0;
      m_a_hex = '0; m_p_hex = '0; m_a_dp = '0; m_p_dp = '0; m_a_den = '0; m_p_den = '0;
      e_seg = {8{cc_ca}}; e_dig = {4{cc_ca}}; e_frame = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      d = (m_k / SD) % HN;
      n = 4'(m_a_hex >> (4 * d));
      r = 8'h00;
      if (1'(m_a_den >> d) && !(LZB && d > 0 && (m_a_hex >> (4 * d)) == 16'h0))
        r = {1'(m_a_dp >> d), font[n]};
      e_seg   = r ^ {8{cc_ca}};
      e_dig   = 4'(1 << d) ^ {4{cc_ca}};
      e_frame = (m_k > 0) && (m_k % FR == 0);
      bnd = (m_k % FR == FR - 1);
      if (upd) begin
        m_p_hex = hex; m_p_dp = dp; m_p_den = den;
        if (bnd) begin
          m_a_hex = hex; m_a_dp = dp; m_a_den = den; m_pend = 1'b0;
        end else m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_a_hex = m_p_hex; m_a_dp = m_p_dp; m_a_den = m_p_den; m_pend = 1'b0;
      end
      m_k++;
    end
    #1;
    if (m_valid) begin
      tests_run++;
      if (seg !== e_seg || dig !== e_dig || frame !== e_frame) begin
        tests_failed++;
        $display("[TB] FAIL model t=%0t seg=%h dig=%b frame=%b required seg=%h dig=%b frame=%b",
                 $time, seg, dig, frame, e_seg, e_dig, e_frame);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      seen = frame;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s frame timeout actual=0 required=1", name);
    end
  endtask

  task automatic wait_dig(input string name, input logic [3:0] want);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      seen = (dig == want);
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s dig timeout actual=%b required=%b", name, dig, want);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] h, input logic [3:0] p, input logic [3:0] e);
    hex = h; dp = p; den = e; upd = 1'b1;
    step();
    upd = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; hex = '0; dp = '0; den = '0; upd = 1'b0; cc_ca = 1'b0;
    steps(3);
    check_output("reset_seg", seg, 8'h00);
    check_output("reset_dig", {4'h0, dig}, 8'h00);
    check_output("reset_frame", {7'h0, frame}, 8'h00);
    reset = 1'b0;
    step();
    check_output("first_dig", {4'h0, dig}, 8'h01);
    steps(4);
    check_output("second_dig", {4'h0, dig}, 8'h02);
    wait_frame("period_a");
    cnt = 0;
    do begin step(); cnt++; end while (!frame && cnt < 40);
    check_output("frame_period", 8'(cnt), 8'd16);

    apply_stimulus(16'h12AF, 4'b0100, 4'hF);
    wait_frame("basic");
    check_output("basic_d0", seg, 8'h71);
    check_output("basic_dig0", {4'h0, dig}, 8'h01);
    steps(4); check_output("basic_d1", seg, 8'h77);
    steps(4); check_output("basic_d2", seg, 8'hDB);
    steps(4); check_output("basic_d3", seg, 8'h06);

    wait_frame("tear_start");
    apply_stimulus(16'h0000, 4'h0, 4'hF);
    wait_dig("tear_d2", 4'b0100);
    apply_stimulus(16'h8888, 4'h0, 4'hF);
    wait_dig("tear_d3", 4'b1000);
    check_output("tear_old_d3", seg, 8'h06);
    wait_frame("tear_new");
    check_output("tear_new_d0", seg, 8'h7F);
    steps(12); check_output("tear_new_d3", seg, 8'h7F);

    wait_frame("simul_sync");
    steps(14);
    apply_stimulus(16'h5555, 4'h0, 4'hF);
    check_output("simul_pend", {7'h0, dut.pend_q}, 8'h00);
    step();
    check_output("simul_frame", {7'h0, frame}, 8'h01);
    check_output("simul_d0", seg, 8'h6D);

    cc_ca = 1'b1;
    apply_stimulus(16'h5555, 4'h0, 4'b1010);
    wait_frame("polarity");
    check_output("pol_d0_seg", seg, 8'hFF);
    check_output("pol_d0_dig", {4'h0, dig}, 8'h0E);
    steps(4);
    check_output("pol_d1_seg", seg, 8'h92);
    check_output("pol_d1_dig", {4'h0, dig}, 8'h0D);

    steps(5);
    reset = 1'b1;
    step();
    check_output("midreset_seg", seg, 8'hFF);
    check_output("midreset_dig", {4'h0, dig}, 8'h0F);
    reset = 1'b0; cc_ca = 1'b0;
    step();
    check_output("postreset_seg", seg, 8'h00);
    check_output("postreset_dig", {4'h0, dig}, 8'h01);

    apply_stimulus(16'h0030, 4'h0, 4'hF);
    wait_frame("lzb_a");
    check_output("lzb_d0", seg, 8'h3F);
    steps(4); check_output("lzb_d1", seg, 8'h4F);
    steps(4); check_output("lzb_d2", seg, LZB ? 8'h00 : 8'h3F);
    steps(4); check_output("lzb_d3", seg, LZB ? 8'h00 : 8'h3F);
    apply_stimulus(16'h0000, 4'h0, 4'hF);
    wait_frame("lzb_b");
    check_output("lzb_zero_d0", seg, 8'h3F);
    steps(4); check_output("lzb_zero_d1", seg, LZB ? 8'h00 : 8'h3F);

    steps(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
